i8255_bus_if: RTL and testbench

Host-side bus interface for the i8255 core. Accepts the asynchronous, active-low 8080-style strobes of an external CPU (CS_n, RD_n, WR_n, A[1:0], D[7:0]), synchronises them into `clk`, and issues the single-cycle, active-high `cs`/`wr`/`rd` pulses with stable `a`/`din` that the core expects. Sits directly upstream of `i8255`, between the package pins and the core.

---
 rtl/i8255_pkg.sv | 18 +
 rtl/i8255_sync.sv | 54 +++++
 rtl/i8255_bus_if.sv | 175 +++++++++++++++++
 tb/tb_i8255_bus_if.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i8255_pkg.sv
// Shared types and constants for the i8255 host bus interface.
// Holds the bus FSM state encoding and the register address map.
// Optional glitch filter macro: I8255_BUS_GLITCH_FILTER_EN.
package i8255_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    WRITE     = 2'd2,
    READ      = 2'd3
  } bus_state_t;

  localparam logic [1:0] I8255_PORT_A = 2'b00;
  localparam logic [1:0] I8255_PORT_B = 2'b01;
  localparam logic [1:0] I8255_PORT_C = 2'b10;
  localparam logic [1:0] I8255_CTRL   = 2'b11;

endpackage

// File: rtl/i8255_sync.sv
// Strobe synchroniser: SYNC_STAGES flops resetting to 1 (inactive).
// Latency: SYNC_STAGES cycles, plus FILTER_LEN when I8255_BUS_GLITCH_FILTER_EN is defined.
// With the filter, the output changes only after FILTER_LEN consecutive identical samples.
module i8255_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;

  // Shift the asynchronous strobe through the metastability chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef I8255_BUS_GLITCH_FILTER_EN
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Flip the filtered level only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (raw == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      filt_q <= raw;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign sync_o = filt_q;
`else
  assign sync_o = raw;
`endif

endmodule

// File: rtl/i8255_bus_if.sv
// Host-side 8080-style bus interface: synchronises CS_n/RD_n/WR_n and issues one-cycle cs/wr/rd pulses.
// Latency: wr commits SYNC_STAGES+1 edges after the strobe rises; rd/oe rise SYNC_STAGES+1 edges after it falls.
// No backpressure; host must respect minimum strobe low/high times. Filter macro: I8255_BUS_GLITCH_FILTER_EN.
module i8255_bus_if
  import i8255_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bus_cs_n,
  input  logic       bus_rd_n,
  input  logic       bus_wr_n,
  input  logic [1:0] bus_a,
  input  logic [7:0] bus_d_in,
  output logic [7:0] bus_d_out,
  output logic       bus_d_oe,
  output logic       bus_err,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [1:0] a,
  output logic [7:0] din,
  input  logic [7:0] core_dout
);

  // The synchroniser flops reset to "inactive", so right after reset they claim
  // the bus is idle even if the host is mid-strobe. Hold WAIT_IDLE until the real
  // pin level has had time to reach the FSM, so an in-flight transaction is dropped.
`ifdef I8255_BUS_GLITCH_FILTER_EN
  localparam int SETTLE = SYNC_STAGES + FILTER_LEN;
`else
  localparam int SETTLE = SYNC_STAGES;
`endif
  localparam int SW = $clog2(SETTLE + 1);

  logic cs_n_s, rd_n_s, wr_n_s;
  logic s_wr, s_rd;

  bus_state_t state_q, state_d;
  logic [SW-1:0] settle_q;
  logic          settle_done;

  logic       cs_q, cs_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] a_q, a_d;
  logic [7:0] din_q, din_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       err_q, err_d;

  i8255_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .async_i(bus_cs_n), .sync_o(cs_n_s)
  );
  i8255_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_rd (
    .clk(clk), .reset_n(reset_n), .async_i(bus_rd_n), .sync_o(rd_n_s)
  );
  i8255_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sync_wr (
    .clk(clk), .reset_n(reset_n), .async_i(bus_wr_n), .sync_o(wr_n_s)
  );

  assign s_wr = !cs_n_s && !wr_n_s;
  assign s_rd = !cs_n_s && !rd_n_s;

  assign settle_done = (settle_q == SW'(SETTLE));

  // Count cycles since reset release until the synchronised strobes are trustworthy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_q <= '0;
    end else if (!settle_done) begin
      settle_q <= settle_q + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_IDLE: if (settle_done && !s_wr && !s_rd) state_d = IDLE;
      IDLE: begin
        if (s_wr && s_rd) state_d = IDLE;
        else if (s_wr)    state_d = WRITE;
        else if (s_rd)    state_d = READ;
      end
      WRITE:   if (!s_wr) state_d = IDLE;
      READ:    if (!s_rd) state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered core and pad outputs
  always_comb begin
    cs_d   = 1'b0;
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    oe_d   = 1'b0;
    a_d    = a_q;
    din_d  = din_q;
    dout_d = dout_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (s_wr && s_rd) begin
          err_d = 1'b1;
        end else if (!s_wr && s_rd) begin
          // Read is issued to the core on entry so data is ready while RD_n is low
          a_d  = bus_a;
          cs_d = 1'b1;
          rd_d = 1'b1;
          oe_d = 1'b1;
        end
      end
      WRITE: begin
        // Track the host bus; the trailing-edge sample is what gets committed
        a_d   = bus_a;
        din_d = bus_d_in;
        if (s_rd) err_d = 1'b1;
        if (!s_wr) begin
          cs_d = 1'b1;
          wr_d = 1'b1;
        end
      end
      READ: begin
        dout_d = core_dout;
        oe_d   = s_rd;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      a_q    <= I8255_PORT_A;
      din_q  <= 8'h00;
      dout_q <= 8'h00;
      oe_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      a_q    <= a_d;
      din_q  <= din_d;
      dout_q <= dout_d;
      oe_q   <= oe_d;
      err_q  <= err_d;
    end
  end

  assign cs        = cs_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign a         = a_q;
  assign din       = din_q;
  assign bus_d_out = dout_q;
  assign bus_d_oe  = oe_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_i8255_bus_if.sv
// Directed bench for i8255_bus_if: writes, reads, protocol error, reset mid-transaction.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Optional glitch-filter steps run when I8255_BUS_GLITCH_FILTER_EN is defined.
module tb_i8255_bus_if;

  localparam int N = 2;
  localparam int F = 3;
`ifdef I8255_BUS_GLITCH_FILTER_EN
  localparam int LAT = N + 1 + F;
  localparam int GAP = N + 2 + F;
`else
  localparam int LAT = N + 1;
  localparam int GAP = N + 2;
`endif
  localparam int LOW = 8;

  logic       clk;
  logic       reset_n;
  logic       bus_cs_n, bus_rd_n, bus_wr_n;
  logic [1:0] bus_a;
  logic [7:0] bus_d_in;
  logic [7:0] bus_d_out;
  logic       bus_d_oe, bus_err;
  logic       cs, wr, rd;
  logic [1:0] a;
  logic [7:0] din;
  logic [7:0] core_dout;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int viol = 0;
  int n0, n1;
  logic wr_prev = 1'b0;
  logic rd_prev = 1'b0;
  logic [9:0] wr_log[$];

  i8255_bus_if #(.SYNC_STAGES(N), .FILTER_LEN(F)) dut (
    .clk(clk), .reset_n(reset_n),
    .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_a(bus_a), .bus_d_in(bus_d_in),
    .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_err(bus_err),
    .cs(cs), .wr(wr), .rd(rd), .a(a), .din(din),
    .core_dout(core_dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Log every core pulse and flag overlapping or stretched pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr) wr_log.push_back({a, din});
      if (rd) rd_cnt++;
      if (wr && rd) viol++;
      if ((wr && wr_prev) || (rd && rd_prev)) viol++;
    end
    wr_prev = wr;
    rd_prev = rd;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] addr, input logic [7:0] data, input int low, input int high);
    bus_a = addr; bus_d_in = data;
    bus_cs_n = 1'b0; bus_wr_n = 1'b0;
    step(low);
    bus_cs_n = 1'b1; bus_wr_n = 1'b1;
    step(high);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; bus_cs_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    bus_a = 2'd0; bus_d_in = 8'h00; core_dout = 8'h00;
    step(4);
    check("rst_cs", cs, 0);
    check("rst_wr", wr, 0);
    check("rst_rd", rd, 0);
    check("rst_a", a, 0);
    check("rst_din", din, 0);
    check("rst_dout", bus_d_out, 0);
    check("rst_oe", bus_d_oe, 0);
    check("rst_err", bus_err, 0);
    reset_n = 1'b1;
    step(8);

    // Single write A=3 D=80, committed on the trailing edge
    bus_a = 2'd3; bus_d_in = 8'h80;
    bus_cs_n = 1'b0; bus_wr_n = 1'b0;
    step(LOW);
    bus_cs_n = 1'b1; bus_wr_n = 1'b1;
    step(LAT - 1);
    check("wr_not_early", wr, 0);
    step(1);
    check("wr_pulse", wr, 1);
    check("wr_cs", cs, 1);
    check("wr_rd_low", rd, 0);
    check("wr_a", a, 3);
    check("wr_din", din, 8'h80);
    step(1);
    check("wr_one_cycle", wr, 0);
    check("wr_cs_off", cs, 0);
    step(GAP);

    // Two back-to-back writes at minimum high time
    n0 = wr_log.size();
    host_write(2'd0, 8'hA5, LOW, GAP);
    host_write(2'd1, 8'h5A, LOW, GAP + 4);
    check("b2b_count", wr_log.size(), n0 + 2);
    check("b2b_first", wr_log[n0], {2'd0, 8'hA5});
    check("b2b_second", wr_log[n0 + 1], {2'd1, 8'h5A});

    // Read A=2 with core data 96
    core_dout = 8'h96; bus_a = 2'd2;
    bus_cs_n = 1'b0; bus_rd_n = 1'b0;
    step(LAT - 1);
    check("rd_oe_not_early", bus_d_oe, 0);
    step(1);
    check("rd_pulse", rd, 1);
    check("rd_cs", cs, 1);
    check("rd_wr_low", wr, 0);
    check("rd_oe", bus_d_oe, 1);
    check("rd_a", a, 2);
    step(1);
    check("rd_one_cycle", rd, 0);
    check("rd_dout", bus_d_out, 8'h96);
    check("rd_oe_hold", bus_d_oe, 1);
    step(LOW - LAT - 1);
    bus_cs_n = 1'b1; bus_rd_n = 1'b1;
    step(LAT - 1);
    check("rd_oe_tail", bus_d_oe, 1);
    step(1);
    check("rd_oe_off", bus_d_oe, 0);
    step(GAP);
    check("rd_count", rd_cnt, 1);

    // RD_n and WR_n low together: sticky error, no pulse
    n0 = wr_log.size();
    bus_cs_n = 1'b0; bus_rd_n = 1'b0; bus_wr_n = 1'b0;
    step(LOW);
    check("err_set", bus_err, 1);
    bus_cs_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    step(GAP + 4);
    check("err_sticky", bus_err, 1);
    check("err_no_wr", wr_log.size(), n0);
    check("err_no_rd", rd_cnt, 1);
    reset_n = 1'b0;
    #1;
    check("err_cleared", bus_err, 0);
    step(3);
    reset_n = 1'b1;
    step(8);

    // Reset asserted and released mid-write: that write is dropped
    n1 = wr_log.size();
    bus_a = 2'd1; bus_d_in = 8'h33;
    bus_cs_n = 1'b0; bus_wr_n = 1'b0;
    step(LAT + 1);
    check("pre_rst_capture", a, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_a", a, 0);
    check("mid_rst_din", din, 0);
    check("mid_rst_cs", cs, 0);
    step(2);
    reset_n = 1'b1;
    step(8);
    bus_cs_n = 1'b1; bus_wr_n = 1'b1;
    step(GAP + 4);
    check("rst_drop_write", wr_log.size(), n1);
    host_write(2'd2, 8'hC3, LOW, GAP + 4);
    check("post_rst_count", wr_log.size(), n1 + 1);
    check("post_rst_data", wr_log[n1], {2'd2, 8'hC3});

`ifdef I8255_BUS_GLITCH_FILTER_EN
    // Short glitch is swallowed; a minimum-length strobe commits
    n1 = wr_log.size();
    host_write(2'd0, 8'h11, 1, GAP + 4);
    check("glitch_ignored", wr_log.size(), n1);
    bus_a = 2'd3; bus_d_in = 8'h22;
    bus_cs_n = 1'b0; bus_wr_n = 1'b0;
    step(F + N + 2);
    bus_cs_n = 1'b1; bus_wr_n = 1'b1;
    step(LAT - 1);
    check("filt_wr_not_early", wr, 0);
    step(1);
    check("filt_wr_pulse", wr, 1);
    step(GAP);
    check("filt_count", wr_log.size(), n1 + 1);
    check("filt_data", wr_log[n1], {2'd3, 8'h22});
`endif

    check("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
